// File: rtl/nanorv32_pipe_seq_pkg.sv
// nanorv32_pipe_seq_pkg: shared pipeline-state encodings and micro-ROM defaults
package nanorv32_pipe_seq_pkg;
  localparam int PSTATE_W = 3;
  localparam int DATA_W = 32;
  localparam int UROM_AW_DEF = 5;
  localparam int IRQ_SEQ_START_DEF = 0;
  localparam int RETI_SEQ_START_DEF = 16;
  typedef enum logic [PSTATE_W-1:0] {
    PS_RESET = 3'd0,
    PS_CONT = 3'd1,
    PS_BRANCH = 3'd2,
    PS_WAITLD = 3'd3,
    PS_SEQ = 3'd4,
    PS_SEQ_WAIT = 3'd5
  } pstate_e;
endpackage

// File: rtl/nanorv32_irq_arb.sv
// nanorv32_irq_arb: masked, globally gated, lowest-index-first IRQ arbiter
module nanorv32_irq_arb #(
  parameter int NIRQ = 4
) (
  input  logic [NIRQ-1:0] irq,
  input  logic [NIRQ-1:0] irq_en,
  input  logic            irq_global_en,
  input  logic            interrupt_state,
  output logic            take_irq,
  output logic [3:0]      irq_id,
  output logic [NIRQ-1:0] ack_onehot
);
  logic [NIRQ-1:0] pend;
  always_comb begin
    pend = irq & irq_en;
    take_irq = |pend && irq_global_en && !interrupt_state;
    irq_id = '0;
    for (int i = NIRQ - 1; i >= 0; i--) irq_id = pend[i] ? 4'(i) : irq_id;
    ack_onehot = '0;
    for (int i = 0; i < NIRQ; i++) ack_onehot[i] = irq_id == 4'(i);
  end
endmodule

// File: rtl/nanorv32_pipe_seq.sv
// nanorv32_pipe_seq: pipeline flow control with micro-ROM interrupt entry/return sequencing
module nanorv32_pipe_seq
  import nanorv32_pipe_seq_pkg::*;
#(
  parameter int NIRQ = 4,
  parameter int UROM_AW = UROM_AW_DEF,
  parameter int IRQ_SEQ_START = IRQ_SEQ_START_DEF,
  parameter int IRQ_SEQ_LEN = 8,
  parameter int RETI_SEQ_START = RETI_SEQ_START_DEF,
  parameter int RETI_SEQ_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_taken,
  input  logic                datamem_read,
  input  logic                datamem_write,
  input  logic                hreadyd,
  input  logic                codeif_cpu_ready_r,
  input  logic [NIRQ-1:0]     irq,
  input  logic [NIRQ-1:0]     irq_en,
  input  logic                irq_global_en,
  input  logic                reti_inst_detected,
  output logic                force_stall_pstate,
  output logic                force_stall_pstate2,
  output logic                force_stall_reset,
  output logic                output_new_pc,
  output logic                valid_inst,
  output logic                data_access_cycle,
  output logic [PSTATE_W-1:0] pstate_r,
  output logic [NIRQ-1:0]     irq_ack,
  output logic [3:0]          irq_id,
  output logic                interrupt_state,
  output logic                irq_bypass_inst_reg,
  output logic [UROM_AW-1:0]  urom_addr
);
  if (NIRQ < 1 || NIRQ > 16) begin : g_bad_nirq
    $error("NIRQ must be 1..16");
  end
  if (IRQ_SEQ_LEN < 1 || IRQ_SEQ_START + IRQ_SEQ_LEN > 2 ** UROM_AW) begin : g_bad_irq_seq
    $error("interrupt-entry sequence does not fit the micro-ROM");
  end
  if (RETI_SEQ_LEN < 1 || RETI_SEQ_START + RETI_SEQ_LEN > 2 ** UROM_AW) begin : g_bad_reti_seq
    $error("return sequence does not fit the micro-ROM");
  end
  logic [PSTATE_W-1:0] pstate_q, pstate_d;
  logic [NIRQ-1:0] irq_ack_q, irq_ack_d, ack_onehot;
  logic [3:0] irq_id_q, irq_id_d, arb_id;
  logic interrupt_state_q, interrupt_state_d, seq_kind_q, seq_kind_d;
  logic [UROM_AW-1:0] urom_addr_q, urom_addr_d, seq_cnt_q, seq_cnt_d;
  logic take_irq, reti_q, mem_op, in_branch, decide, advance;
  nanorv32_irq_arb #(.NIRQ(NIRQ)) u_arb (
    .irq            (irq),
    .irq_en         (irq_en),
    .irq_global_en  (irq_global_en),
    .interrupt_state(interrupt_state_q),
    .take_irq       (take_irq),
    .irq_id         (arb_id),
    .ack_onehot     (ack_onehot)
  );
  assign reti_q = reti_inst_detected && interrupt_state_q;
  assign mem_op = datamem_read || datamem_write;
  assign in_branch = pstate_q == PS_BRANCH;
  always_comb begin
    force_stall_pstate = 1'b0;
    force_stall_pstate2 = 1'b0;
    force_stall_reset = 1'b0;
    output_new_pc = 1'b0;
    data_access_cycle = 1'b0;
    valid_inst = 1'b1;
    pstate_d = PS_CONT;
    irq_ack_d = '0;
    irq_id_d = irq_id_q;
    interrupt_state_d = interrupt_state_q;
    seq_kind_d = seq_kind_q;
    urom_addr_d = urom_addr_q;
    seq_cnt_d = seq_cnt_q;
    decide = 1'b0;
    advance = 1'b0;
    case (pstate_q)
      PS_RESET: begin
        force_stall_pstate = 1'b1;
        force_stall_pstate2 = 1'b1;
        force_stall_reset = 1'b1;
        valid_inst = 1'b0;
      end
      PS_CONT: decide = 1'b1;
      PS_BRANCH: begin
        decide = codeif_cpu_ready_r;
        output_new_pc = !codeif_cpu_ready_r;
        force_stall_pstate = !codeif_cpu_ready_r;
        valid_inst = codeif_cpu_ready_r;
        pstate_d = codeif_cpu_ready_r ? PS_CONT : PS_BRANCH;
      end
      PS_WAITLD, PS_SEQ_WAIT: begin
        decide = hreadyd && pstate_q == PS_WAITLD;
        advance = hreadyd && pstate_q == PS_SEQ_WAIT;
        force_stall_pstate = !hreadyd;
        force_stall_pstate2 = !hreadyd;
        valid_inst = hreadyd;
        pstate_d = hreadyd ? PS_CONT : pstate_q;
      end
      PS_SEQ: begin
        advance = !mem_op;
        data_access_cycle = mem_op;
        force_stall_pstate2 = mem_op;
        pstate_d = mem_op ? PS_SEQ_WAIT : PS_CONT;
      end
      default: ;
    endcase
    if (decide) begin
      if (branch_taken && !in_branch) begin
        force_stall_pstate = 1'b1;
        output_new_pc = 1'b1;
        pstate_d = PS_BRANCH;
      end else if (mem_op && !in_branch) begin
        data_access_cycle = 1'b1;
        force_stall_pstate2 = 1'b1;
        pstate_d = PS_WAITLD;
      end else if (take_irq) begin
        pstate_d = PS_SEQ;
        seq_kind_d = 1'b0;
        urom_addr_d = UROM_AW'(IRQ_SEQ_START);
        seq_cnt_d = UROM_AW'(IRQ_SEQ_LEN - 1);
        irq_id_d = arb_id;
        irq_ack_d = ack_onehot;
      end else if (reti_q) begin
        pstate_d = PS_SEQ;
        seq_kind_d = 1'b1;
        urom_addr_d = UROM_AW'(RETI_SEQ_START);
        seq_cnt_d = UROM_AW'(RETI_SEQ_LEN - 1);
      end
    end
    if (advance) begin
      if (seq_cnt_q != '0) begin
        urom_addr_d = urom_addr_q + 1'b1;
        seq_cnt_d = seq_cnt_q - 1'b1;
        pstate_d = PS_SEQ;
      end else begin
        output_new_pc = 1'b1;
        force_stall_pstate = 1'b1;
        pstate_d = PS_BRANCH;
        interrupt_state_d = !seq_kind_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q <= PS_RESET;
      irq_ack_q <= '0;
      irq_id_q <= '0;
      interrupt_state_q <= 1'b0;
      urom_addr_q <= '0;
      seq_cnt_q <= '0;
      seq_kind_q <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      irq_ack_q <= irq_ack_d;
      irq_id_q <= irq_id_d;
      interrupt_state_q <= interrupt_state_d;
      urom_addr_q <= urom_addr_d;
      seq_cnt_q <= seq_cnt_d;
      seq_kind_q <= seq_kind_d;
    end
  end
  assign pstate_r = pstate_q;
  assign irq_ack = irq_ack_q;
  assign irq_id = irq_id_q;
  assign interrupt_state = interrupt_state_q;
  assign urom_addr = urom_addr_q;
  assign irq_bypass_inst_reg = pstate_q == PS_SEQ || pstate_q == PS_SEQ_WAIT;
endmodule

// File: tb/tb_nanorv32_pipe_seq.sv
// tb_nanorv32_pipe_seq: directed plan scenarios plus random traffic against a queue-based reference model
module tb_nanorv32_pipe_seq;
  localparam int IRQ_START = 0, IRQ_LEN = 3, RETI_START = 16, RETI_LEN = 8;
  logic clk = 0, rst = 1;
  logic branch_taken = 0, datamem_read = 0, datamem_write = 0, hreadyd = 1, codeif_cpu_ready_r = 1;
  logic [3:0] irq = 0, irq_en = 0;
  logic irq_global_en = 0, reti_inst_detected = 0;
  logic force_stall_pstate, force_stall_pstate2, force_stall_reset, output_new_pc, valid_inst;
  logic data_access_cycle, interrupt_state, irq_bypass_inst_reg;
  logic [2:0] pstate_r;
  logic [3:0] irq_ack, irq_id;
  logic [4:0] urom_addr;
  int vectors = 0, miscompares = 0;
  nanorv32_pipe_seq #(.NIRQ(4), .UROM_AW(5), .IRQ_SEQ_START(IRQ_START), .IRQ_SEQ_LEN(IRQ_LEN),
    .RETI_SEQ_START(RETI_START), .RETI_SEQ_LEN(RETI_LEN)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .datamem_read(datamem_read),
    .datamem_write(datamem_write), .hreadyd(hreadyd), .codeif_cpu_ready_r(codeif_cpu_ready_r),
    .irq(irq), .irq_en(irq_en), .irq_global_en(irq_global_en), .reti_inst_detected(reti_inst_detected),
    .force_stall_pstate(force_stall_pstate), .force_stall_pstate2(force_stall_pstate2),
    .force_stall_reset(force_stall_reset), .output_new_pc(output_new_pc), .valid_inst(valid_inst),
    .data_access_cycle(data_access_cycle), .pstate_r(pstate_r), .irq_ack(irq_ack), .irq_id(irq_id),
    .interrupt_state(interrupt_state), .irq_bypass_inst_reg(irq_bypass_inst_reg), .urom_addr(urom_addr));
  always #5 clk = ~clk;
  // Reference model: the running micro-sequence is a queue of the addresses still to execute.
  int m_st = 0, m_id = 0, m_urom = 0, m_low = 0, n_st, act;
  bit m_intr = 0, m_kind = 0, armed = 0;
  bit [3:0] m_ack = 0;
  int useq[$];
  bit e_fsp, e_fsp2, e_fsr, e_npc, e_vi, e_dac;
  task automatic chk(string name, int act_v, int exp_v);
    vectors++;
    if (act_v != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask
  task automatic pipeline_choice(bit full);
    bit [3:0] pend;
    pend = irq & irq_en;
    m_low = 0;
    for (int i = 3; i >= 0; i--) if (pend[i]) m_low = i;
    if (full && branch_taken) begin e_fsp = 1; e_npc = 1; n_st = 2; end
    else if (full && (datamem_read || datamem_write)) begin e_dac = 1; e_fsp2 = 1; n_st = 3; end
    else if (pend != 0 && irq_global_en && !m_intr) begin n_st = 4; act = 1; end
    else if (reti_inst_detected && m_intr) begin n_st = 4; act = 2; end
  endtask
  task automatic step_seq();
    if (useq.size() > 1) begin n_st = 4; act = 3; end
    else begin e_npc = 1; e_fsp = 1; n_st = 2; act = 4; end
  endtask
  task automatic model_comb();
    bit mem;
    mem = datamem_read || datamem_write;
    {e_fsp, e_fsp2, e_fsr, e_npc, e_dac} = '0;
    e_vi = 1;
    n_st = 1;
    act = 0;
    if (m_st == 0) begin e_fsp = 1; e_fsp2 = 1; e_fsr = 1; e_vi = 0; end
    else if (m_st == 1) pipeline_choice(1);
    else if (m_st == 2 && codeif_cpu_ready_r) pipeline_choice(0);
    else if (m_st == 2) begin e_npc = 1; e_fsp = 1; e_vi = 0; n_st = 2; end
    else if ((m_st == 3 || m_st == 5) && !hreadyd) begin e_fsp = 1; e_fsp2 = 1; e_vi = 0; n_st = m_st; end
    else if (m_st == 3) pipeline_choice(1);
    else if (m_st == 4 && mem) begin e_dac = 1; e_fsp2 = 1; n_st = 5; end
    else step_seq();
  endtask
  task automatic model_commit();
    if (rst) begin
      m_st = 0; m_ack = 0; m_id = 0; m_intr = 0; m_urom = 0; m_kind = 0;
      useq.delete();
      armed = 1;
      return;
    end
    m_st = n_st;
    m_ack = 0;
    if (act == 1 || act == 2) begin
      m_kind = act == 2;
      useq.delete();
      for (int i = 0; i < (m_kind ? RETI_LEN : IRQ_LEN); i++) useq.push_back((m_kind ? RETI_START : IRQ_START) + i);
      m_urom = useq[0];
      if (act == 1) begin m_id = m_low; m_ack = 4'(1 << m_low); end
    end else if (act == 3) begin
      void'(useq.pop_front());
      m_urom = useq[0];
    end else if (act == 4) begin
      m_intr = !m_kind;
      useq.delete();
    end
  endtask
  task automatic compare_all();
    chk("pstate_r", pstate_r, m_st);
    chk("irq_ack", irq_ack, m_ack);
    chk("irq_id", irq_id, m_id);
    chk("interrupt_state", interrupt_state, m_intr);
    chk("urom_addr", urom_addr, m_urom);
    chk("irq_bypass_inst_reg", irq_bypass_inst_reg, m_st == 4 || m_st == 5);
    chk("force_stall_pstate", force_stall_pstate, e_fsp);
    chk("force_stall_pstate2", force_stall_pstate2, e_fsp2);
    chk("force_stall_reset", force_stall_reset, e_fsr);
    chk("output_new_pc", output_new_pc, e_npc);
    chk("valid_inst", valid_inst, e_vi);
    chk("data_access_cycle", data_access_cycle, e_dac);
  endtask
  task automatic tick();
    #1;
    model_comb();
    if (armed) compare_all();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    tick(); tick();
    chk("lit_reset_pstate", pstate_r, 0);
    chk("lit_reset_stall", force_stall_reset, 1);
    rst = 0;
    tick();
    chk("lit_idle_pstate", pstate_r, 1);
    chk("lit_idle_valid", valid_inst, 1);
    chk("lit_idle_urom", urom_addr, 0);
    datamem_read = 1; hreadyd = 0; #1;
    chk("lit_load_dac", data_access_cycle, 1);
    tick();
    datamem_read = 0;
    chk("lit_waitld", pstate_r, 3);
    tick(); tick();
    hreadyd = 1;
    tick();
    chk("lit_load_done", pstate_r, 1);
    irq = 4'b1010; irq_en = 4'hF; irq_global_en = 1;
    tick();
    chk("lit_irq_seq", pstate_r, 4);
    chk("lit_irq_id", irq_id, 1);
    chk("lit_irq_ack", irq_ack, 4'b0010);
    chk("lit_urom0", urom_addr, 0);
    tick();
    chk("lit_ack_pulse", irq_ack, 0);
    chk("lit_urom1", urom_addr, 1);
    tick();
    chk("lit_urom2", urom_addr, 2);
    tick();
    chk("lit_irq_branch", pstate_r, 2);
    chk("lit_intr_set", interrupt_state, 1);
    irq = 4'b0001;
    tick(); tick();
    chk("lit_no_nest_ack", irq_ack, 0);
    chk("lit_no_nest_st", pstate_r, 1);
    irq = 0; reti_inst_detected = 1;
    tick();
    reti_inst_detected = 0;
    chk("lit_reti_urom16", urom_addr, 16);
    repeat (7) tick();
    chk("lit_reti_urom23", urom_addr, 23);
    tick();
    chk("lit_reti_branch", pstate_r, 2);
    chk("lit_intr_clr", interrupt_state, 0);
    tick();
    reti_inst_detected = 1;
    tick(); tick();
    chk("lit_reti_ignored", pstate_r, 1);
    reti_inst_detected = 0;
    branch_taken = 1; irq = 4'b0100;
    tick();
    branch_taken = 0;
    chk("lit_branch_first", pstate_r, 2);
    tick();
    chk("lit_irq_after_branch", irq_id, 2);
    irq = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 199) == 0;
      branch_taken = $urandom_range(0, 7) == 0;
      datamem_read = $urandom_range(0, 5) == 0;
      datamem_write = $urandom_range(0, 7) == 0;
      hreadyd = $urandom_range(0, 2) != 0;
      codeif_cpu_ready_r = $urandom_range(0, 2) != 0;
      irq = $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 15)) : 4'h0;
      irq_en = 4'($urandom_range(0, 15));
      irq_global_en = $urandom_range(0, 3) != 0;
      reti_inst_detected = $urandom_range(0, 5) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
